// File: rtl/poly_param_loader.sv
// poly_param_loader: SPI mode-0 loader for polygon parameters, with a frame-synchronous shadow swap
// Ports: clk, rst_n (async active-low) | spi_sck, spi_cs_n, spi_mosi (serial slave, MSB first)
//        frame_start (vblank pulse) | cmp_en, background_color, poly_color, v0_x..v2_y (active buses,
//        slot 0 at LSBs) | update_pending (shadow holds a write not yet copied to the outputs)
// Option: POLY_LOADER_SHADOW_EN enables the shadow register file; without it commits go straight to the outputs.
`ifndef N_POLY
`define N_POLY 3
`endif
`ifndef WPX
`define WPX 8
`endif
`ifndef WPY
`define WPY 7
`endif
`ifndef WCOLOR
`define WCOLOR 6
`endif

module poly_param_loader #(
    parameter int N_POLY = `N_POLY,
    parameter int WPX    = `WPX,
    parameter int WPY    = `WPY,
    parameter int WCOLOR = `WCOLOR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_sck,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    input  logic                     frame_start,
    output logic [N_POLY-1:0]        cmp_en,
    output logic [WCOLOR-1:0]        background_color,
    output logic [WCOLOR*N_POLY-1:0] poly_color,
    output logic [WPX*N_POLY-1:0]    v0_x,
    output logic [WPX*N_POLY-1:0]    v1_x,
    output logic [WPX*N_POLY-1:0]    v2_x,
    output logic [WPY*N_POLY-1:0]    v0_y,
    output logic [WPY*N_POLY-1:0]    v1_y,
    output logic [WPY*N_POLY-1:0]    v2_y,
    output logic                     update_pending
);
    localparam int REC = 3*WPX + 3*WPY + WCOLOR;
    localparam int PB  = (REC + 7) / 8 * 8;
    localparam int CW  = $clog2(PB + 1);

    typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, WAIT_CS, DROP} state_t;
    state_t state, state_nxt;

    logic [2:0]    sck_s;
    logic [1:0]    cs_s, mosi_s;
    logic          cs_d, sck_rise, cs_fall, cs_rise, bit_en, commit, cmd_ok;
    logic [CW-1:0] cnt, last;
    logic [7:0]    cmd, cmd_nxt;
    logic [PB-1:0] sr;

    logic [N_POLY-1:0][REC-1:0] act_rec;
    logic [N_POLY-1:0]          act_en;
    logic [WCOLOR-1:0]          act_bg;

    // cs_n synchroniser resets to the deasserted level so reset release never looks like a cs fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= '0;
            cs_s   <= 2'b11;
            mosi_s <= '0;
            cs_d   <= 1'b1;
        end else begin
            sck_s  <= {sck_s[1:0], spi_sck};
            cs_s   <= {cs_s[0], spi_cs_n};
            mosi_s <= {mosi_s[0], spi_mosi};
            cs_d   <= cs_s[1];
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign bit_en   = sck_rise & ~cs_s[1];
    assign cs_fall  = cs_d & ~cs_s[1];
    assign cs_rise  = ~cs_d & cs_s[1];
    assign cmd_nxt  = {cmd[6:0], mosi_s[1]};
    assign cmd_ok   = (cmd_nxt[7:6] == 2'b01) || (cmd_nxt[7:6] == 2'b10) ||
                      (cmd_nxt[7:6] == 2'b00 && 32'(cmd_nxt[1:0]) < N_POLY);
    assign last     = (cmd[7:6] == 2'b00) ? CW'(PB - 1) : CW'(7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = CMD;
            CMD:     if (cs_rise) state_nxt = IDLE;
                     else if (bit_en && cnt == CW'(7)) state_nxt = cmd_ok ? PAYLOAD : DROP;
            PAYLOAD: if (cs_rise) state_nxt = IDLE;
                     else if (bit_en && cnt == last) state_nxt = WAIT_CS;
            default: if (cs_rise) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        commit = (state == WAIT_CS) && cs_rise;
    end

    // The payload is right-aligned, so shifting every payload bit in leaves the fields at the LSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            cmd <= '0;
            sr  <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (bit_en && (state == CMD || state == PAYLOAD)) begin
            cnt <= (state == CMD && cnt == CW'(7)) ? '0 : cnt + CW'(1);
            if (state == CMD) cmd <= cmd_nxt;
            else              sr  <= {sr[PB-2:0], mosi_s[1]};
        end
    end

`ifdef POLY_LOADER_SHADOW_EN
    logic [N_POLY-1:0][REC-1:0] sh_rec;
    logic [N_POLY-1:0]          sh_en;
    logic [WCOLOR-1:0]          sh_bg;
    logic                       dirty;
    logic                       unused_ok;

    // A commit coinciding with frame_start lands in the shadow only; the swap copies the old shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_rec  <= '0;
            sh_en   <= '0;
            sh_bg   <= '0;
            dirty   <= 1'b0;
            act_rec <= '0;
            act_en  <= '0;
            act_bg  <= '0;
        end else begin
            if (commit) begin
                for (int i = 0; i < N_POLY; i++)
                    if (cmd[7:6] == 2'b00 && cmd[1:0] == 2'(i)) sh_rec[i] <= sr[REC-1:0];
                if (cmd[7:6] == 2'b01) sh_bg <= sr[WCOLOR-1:0];
                if (cmd[7:6] == 2'b10) sh_en <= sr[N_POLY-1:0];
            end
            if (frame_start && dirty) begin
                act_rec <= sh_rec;
                act_en  <= sh_en;
                act_bg  <= sh_bg;
            end
            dirty <= commit | (dirty & ~frame_start);
        end
    end

    assign update_pending = dirty;
    assign unused_ok      = sr[PB-1];
`else
    logic unused_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_rec <= '0;
            act_en  <= '0;
            act_bg  <= '0;
        end else if (commit) begin
            for (int i = 0; i < N_POLY; i++)
                if (cmd[7:6] == 2'b00 && cmd[1:0] == 2'(i)) act_rec[i] <= sr[REC-1:0];
            if (cmd[7:6] == 2'b01) act_bg <= sr[WCOLOR-1:0];
            if (cmd[7:6] == 2'b10) act_en <= sr[N_POLY-1:0];
        end
    end

    assign update_pending = 1'b0;
    assign unused_ok      = sr[PB-1] ^ frame_start;
`endif

    assign cmp_en           = act_en;
    assign background_color = act_bg;

    // Record layout from MSB: v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color
    for (genvar g = 0; g < N_POLY; g++) begin : g_slot
        assign poly_color[g*WCOLOR +: WCOLOR] = act_rec[g][0 +: WCOLOR];
        assign v2_y[g*WPY +: WPY]             = act_rec[g][WCOLOR +: WPY];
        assign v2_x[g*WPX +: WPX]             = act_rec[g][WCOLOR + WPY +: WPX];
        assign v1_y[g*WPY +: WPY]             = act_rec[g][WCOLOR + WPY + WPX +: WPY];
        assign v1_x[g*WPX +: WPX]             = act_rec[g][WCOLOR + 2*WPY + WPX +: WPX];
        assign v0_y[g*WPY +: WPY]             = act_rec[g][WCOLOR + 2*WPY + 2*WPX +: WPY];
        assign v0_x[g*WPX +: WPX]             = act_rec[g][WCOLOR + 3*WPY + 2*WPX +: WPX];
    end
endmodule
